// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-stage branch predictor: counter encoding, BTB entry, opcodes.
// Package bp_types; imported by btb and branch_predictor.
package bp_types;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bp_cnt_t;

    localparam bp_cnt_t BP_CNT_RESET = WEAK_NT;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // Tag is held in a full word-address-wide field; only the low 30-IDX bits are ever non-zero.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        logic        is_jump;
    } btb_entry_t;

    function automatic bp_cnt_t sat_update(input bp_cnt_t cnt, input logic taken);
        bp_cnt_t nxt;
        nxt = cnt;
        case (cnt)
            STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
            default:   nxt = BP_CNT_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer: combinational read port, one synchronous write port.
// Only valid bits are reset; tag/target/is_jump are don't-care until written.
module btb
    import bp_types::*;
#(
    parameter int IDX_BITS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] rd_word,
    output logic        rd_hit,
    output logic [31:0] rd_target,
    output logic        rd_is_jump,
    input  logic        wr_en,
    input  logic [29:0] wr_word,
    input  logic [31:0] wr_target,
    input  logic        wr_is_jump
);

    localparam int ENTRIES = 1 << IDX_BITS;

    btb_entry_t mem [ENTRIES];
    btb_entry_t rd_entry;

    assign rd_entry   = mem[rd_word[IDX_BITS-1:0]];
    assign rd_hit     = rd_entry.valid && (rd_entry.tag == 30'(rd_word[29:IDX_BITS]));
    assign rd_target  = rd_entry.target;
    assign rd_is_jump = rd_entry.is_jump;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            mem[wr_word[IDX_BITS-1:0]] <= '{valid:   1'b1,
                                           tag:     30'(wr_word[29:IDX_BITS]),
                                           target:  wr_target,
                                           is_jump: wr_is_jump};
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal (or gshare with BP_GSHARE_EN) branch predictor with BTB and EX-stage resolution check.
// Define BP_GSHARE_EN to XOR a global history register into the counter index.
module branch_predictor
    import bp_types::*;
#(
    parameter int BHT_IDX_BITS = 6,
    parameter int BTB_IDX_BITS = 5,
    parameter int GHR_BITS     = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                predict_en,
    input  logic [31:0]         if_pc,
    output logic                pred_taken,
    output logic [31:0]         pred_target,
`ifdef BP_GSHARE_EN
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic [GHR_BITS-1:0] ex_ghr,
`endif
    input  logic                ex_valid,
    input  logic [6:0]          ex_opcode,
    input  logic [31:0]         ex_pc,
    input  logic                ex_br_en,
    input  logic [31:0]         ex_target,
    input  logic                ex_pred_taken,
    input  logic [31:0]         ex_pred_target,
    output logic                prediction_failed,
    output logic [31:0]         redirect_pc
);

    localparam int BHT_SIZE = 1 << BHT_IDX_BITS;

    bp_cnt_t                 cnt [BHT_SIZE];
    bp_cnt_t                 cnt_rd;
    logic [BHT_IDX_BITS-1:0] if_bht_idx;
    logic [BHT_IDX_BITS-1:0] ex_bht_idx;
    logic                    btb_hit;
    logic [31:0]             btb_target;
    logic                    btb_is_jump;
    logic                    is_br;
    logic                    is_jal;
    logic                    is_jalr;
    logic                    actual;
    logic                    upd;

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr;

    assign pred_ghr   = ghr;
    assign if_bht_idx = if_pc[BHT_IDX_BITS+1:2] ^ BHT_IDX_BITS'(ghr);
    assign ex_bht_idx = ex_pc[BHT_IDX_BITS+1:2] ^ BHT_IDX_BITS'(ex_ghr);

    // History advances only on resolved branches, never speculatively at fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (upd && is_br) begin
            ghr <= GHR_BITS'({ghr, actual});
        end
    end
`else
    assign if_bht_idx = if_pc[BHT_IDX_BITS+1:2];
    assign ex_bht_idx = ex_pc[BHT_IDX_BITS+1:2];
`endif

    // IF prediction: reads pre-update state, so a same-cycle EX write is not bypassed.
    assign cnt_rd      = cnt[if_bht_idx];
    assign pred_taken  = ~rst & btb_hit & (btb_is_jump | cnt_rd[1]);
    assign pred_target = pred_taken ? btb_target : if_pc + 32'd4;

    assign is_br   = (ex_opcode == OP_BR);
    assign is_jal  = (ex_opcode == OP_JAL);
    assign is_jalr = (ex_opcode == OP_JALR);
    assign actual  = is_jal | is_jalr | (is_br & ex_br_en);
    assign upd     = ex_valid & predict_en & ~rst & (is_br | is_jal | is_jalr);

    assign prediction_failed = ex_valid & ~rst &
                               ((actual != ex_pred_taken) |
                                (actual & (ex_pred_target != ex_target)));
    assign redirect_pc       = actual ? ex_target : ex_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_SIZE; i++) begin
                cnt[i] <= BP_CNT_RESET;
            end
        end else if (upd && is_br) begin
            cnt[ex_bht_idx] <= sat_update(cnt[ex_bht_idx], actual);
        end
    end

    btb #(
        .IDX_BITS(BTB_IDX_BITS)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .rd_word    (if_pc[31:2]),
        .rd_hit     (btb_hit),
        .rd_target  (btb_target),
        .rd_is_jump (btb_is_jump),
        .wr_en      (upd & actual),
        .wr_word    (ex_pc[31:2]),
        .wr_target  (ex_target),
        .wr_is_jump (~is_br)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized bench for branch_predictor (default bimodal build).
module tb_branch_predictor;

    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] ALU  = 7'b0110011;

    logic        clk;
    logic        rst;
    logic        predict_en;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [31:0] ex_pc;
    logic        ex_br_en;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        prediction_failed;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    // Reference state: counters as plain integers 0..3, BTB as the full PC last written per slot.
    int          m_cnt [64];
    bit          m_val [32];
    logic [31:0] m_pc  [32];
    logic [31:0] m_tgt [32];
    bit          m_jmp [32];

    logic        o_pt;
    logic [31:0] o_ptg;
    logic        o_fail;
    logic [31:0] o_redir;

    branch_predictor dut (
        .clk               (clk),
        .rst               (rst),
        .predict_en        (predict_en),
        .if_pc             (if_pc),
        .pred_taken        (pred_taken),
        .pred_target       (pred_target),
        .ex_valid          (ex_valid),
        .ex_opcode         (ex_opcode),
        .ex_pc             (ex_pc),
        .ex_br_en          (ex_br_en),
        .ex_target         (ex_target),
        .ex_pred_taken     (ex_pred_taken),
        .ex_pred_target    (ex_pred_target),
        .prediction_failed (prediction_failed),
        .redirect_pc       (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_cnt[i] = 1;
        for (int i = 0; i < 32; i++) m_val[i] = 0;
    endtask

    task automatic model_pred(input logic [31:0] pc, output bit t, output logic [31:0] tg);
        int bi;
        int ti;
        bit hit;
        bi  = int'((pc >> 2) % 64);
        ti  = int'((pc >> 2) % 32);
        hit = m_val[ti] && ((m_pc[ti] >> 7) == (pc >> 7));
        t   = hit && (m_jmp[ti] || m_cnt[bi] >= 2);
        tg  = t ? m_tgt[ti] : pc + 4;
    endtask

    task automatic step(input bit rs, input bit v, input logic [6:0] op,
                        input logic [31:0] epc, input bit br, input logic [31:0] tgt,
                        input bit ept, input logic [31:0] eptg,
                        input logic [31:0] ipc, input bit pe);
        bit          e_pt;
        logic [31:0] e_ptg;
        bit          ctl;
        bit          act;
        bit          e_fail;
        logic [31:0] e_redir;
        int          bi;
        int          ti;
        rst = rs; ex_valid = v; ex_opcode = op; ex_pc = epc; ex_br_en = br;
        ex_target = tgt; ex_pred_taken = ept; ex_pred_target = eptg;
        if_pc = ipc; predict_en = pe;
        @(negedge clk);
        if (rs) begin
            e_pt = 0; e_ptg = ipc + 4;
        end else begin
            model_pred(ipc, e_pt, e_ptg);
        end
        ctl     = (op == BR) || (op == JAL) || (op == JALR);
        act     = (op == JAL) || (op == JALR) || (op == BR && br);
        e_fail  = v && !rs && ((act != ept) || (act && eptg != tgt));
        e_redir = act ? tgt : epc + 4;
        o_pt = pred_taken; o_ptg = pred_target; o_fail = prediction_failed; o_redir = redirect_pc;
        chk("pred_taken", {31'b0, o_pt}, {31'b0, e_pt});
        chk("pred_target", o_ptg, e_ptg);
        chk("prediction_failed", {31'b0, o_fail}, {31'b0, e_fail});
        chk("redirect_pc", o_redir, e_redir);
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else if (v && pe && ctl) begin
            bi = int'((epc >> 2) % 64);
            ti = int'((epc >> 2) % 32);
            if (op == BR) m_cnt[bi] = br ? (m_cnt[bi] == 3 ? 3 : m_cnt[bi] + 1)
                                         : (m_cnt[bi] == 0 ? 0 : m_cnt[bi] - 1);
            if (act) begin
                m_val[ti] = 1; m_pc[ti] = epc; m_tgt[ti] = tgt; m_jmp[ti] = (op != BR);
            end
        end
        #1;
    endtask

    task automatic idle(input logic [31:0] ipc);
        step(0, 0, ALU, 32'h0, 0, 32'h0, 0, 32'h4, ipc, 1);
    endtask

    initial begin
        bit          mt;
        logic [31:0] mtg;
        logic [31:0] rpc;
        logic [6:0]  rop;
        model_reset();
        rst = 1; predict_en = 1; if_pc = 0; ex_valid = 0; ex_opcode = ALU; ex_pc = 0;
        ex_br_en = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
        @(posedge clk); #1;

        // Reset: no prediction, no misprediction even with a live EX instruction.
        step(1, 1, BR, 32'h80, 1, 32'h40, 0, 32'h84, 32'h60, 1);
        chk("rst_pred_taken", {31'b0, o_pt}, 32'd0);
        chk("rst_pred_target", o_ptg, 32'h64);
        chk("rst_failed", {31'b0, o_fail}, 32'd0);

        // First taken branch: mispredicted, then predicted taken on next fetch.
        step(0, 1, BR, 32'h80, 1, 32'h40, 0, 32'h84, 32'h80, 1);
        chk("first_br_failed", {31'b0, o_fail}, 32'd1);
        chk("first_br_redirect", o_redir, 32'h40);
        chk("same_cycle_no_bypass", {31'b0, o_pt}, 32'd0);
        idle(32'h80);
        chk("trained_taken", {31'b0, o_pt}, 32'd1);
        chk("trained_target", o_ptg, 32'h40);

        // Saturate to strongly taken, then one not-taken only weakens it.
        for (int i = 0; i < 4; i++) step(0, 1, BR, 32'h80, 1, 32'h40, 1, 32'h40, 32'h80, 1);
        step(0, 1, BR, 32'h80, 0, 32'h40, 1, 32'h40, 32'h60, 1);
        chk("nt_failed", {31'b0, o_fail}, 32'd1);
        chk("nt_redirect", o_redir, 32'h84);
        idle(32'h80);
        chk("still_taken", {31'b0, o_pt}, 32'd1);

        // Tag mismatch at an aliasing BTB slot.
        idle(32'h100);
        chk("btb_miss_taken", {31'b0, o_pt}, 32'd0);
        chk("btb_miss_target", o_ptg, 32'h104);

        // Stall: held branch updates once only when predict_en returns.
        step(0, 1, BR, 32'h80, 0, 32'h40, 1, 32'h40, 32'h60, 1);
        for (int i = 0; i < 3; i++) step(0, 1, BR, 32'h80, 1, 32'h40, 0, 32'h84, 32'h60, 0);
        step(0, 1, BR, 32'h80, 1, 32'h40, 0, 32'h84, 32'h60, 1);
        step(0, 1, BR, 32'h80, 0, 32'h40, 0, 32'h84, 32'h60, 1);
        idle(32'h80);
        chk("stall_single_update", {31'b0, o_pt}, 32'd0);

        // Jalr with wrong predicted target; retrains to an unconditional entry.
        step(0, 1, JALR, 32'h200, 0, 32'h310, 1, 32'h300, 32'h60, 1);
        chk("jalr_failed", {31'b0, o_fail}, 32'd1);
        chk("jalr_redirect", o_redir, 32'h310);
        idle(32'h200);
        chk("jalr_is_jump", {31'b0, o_pt}, 32'd1);
        chk("jalr_target", o_ptg, 32'h310);

        // Mid-run reset masks a trained entry and clears the BTB.
        step(1, 1, JAL, 32'h400, 0, 32'h500, 0, 32'h404, 32'h200, 1);
        chk("rst2_taken", {31'b0, o_pt}, 32'd0);
        chk("rst2_target", o_ptg, 32'h204);
        chk("rst2_failed", {31'b0, o_fail}, 32'd0);
        idle(32'h200);
        chk("post_rst_cleared", {31'b0, o_pt}, 32'd0);

        // Randomized traffic over a small aliasing address pool.
        for (int n = 0; n < 400; n++) begin
            rpc = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 2);
            case ($urandom_range(0, 3))
                0: rop = JAL;
                1: rop = JALR;
                2: rop = ALU;
                default: rop = BR;
            endcase
            if ($urandom_range(0, 2) != 0) model_pred(rpc, mt, mtg);
            else begin
                mt  = 1'($urandom_range(0, 1));
                mtg = 32'($urandom_range(0, 255)) << 2;
            end
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), rop, rpc,
                 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2, mt, mtg,
                 (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 2),
                 ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Fetch-stage dynamic branch predictor and EX-stage resolution checker for the pipelined RV32I core.
- Prediction: a direct-mapped BTB plus a table of 2-bit saturating counters supply the next-PC guess for the IF-stage PC.
- Resolution: at EX, the carried prediction is compared against the actual outcome. This produces `prediction_failed` and `redirect_pc` for the hazard unit and PC mux.
- Updates are gated by the hazard unit's `predict_en`.

Parameters:
- BHT_IDX_BITS, 6, log2 of counter-table entries.
- BTB_IDX_BITS, 5, log2 of BTB entries. Tag width = 30 - BTB_IDX_BITS.
- GHR_BITS, 6, global history length (used only with BP_GSHARE_EN). Must be ≤ BHT_IDX_BITS.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- predict_en  in  1  table/history update enable from the hazard unit
- if_pc  in  32  PC being fetched
- pred_taken  out  1  IF prediction: taken
- pred_target  out  32  IF predicted next PC
- ex_valid  in  1  EX holds a real (non-bubble) instruction
- ex_opcode  in  7  rv32i_opcode of the EX instruction
- ex_pc  in  32  PC of the EX instruction
- ex_br_en  in  1  branch comparison result (op_br only)
- ex_target  in  32  computed target: jalr target already LSB-cleared
- ex_pred_taken  in  1  pred_taken carried down from IF
- ex_pred_target  in  32  pred_target carried down from IF
- prediction_failed  out  1  EX misprediction; feeds the hazard unit
- redirect_pc  out  32  correct next PC on misprediction

Behaviour:
- State:
  - Counter table cnt[2^BHT_IDX_BITS], 2-bit each.
  - BTB entries: {valid, tag, target[31:0], is_jump}.
  - Optional GHR (global history register).
- Reset (1 cycle, synchronous):
  - All cnt = 2'b01 (weakly not-taken).
  - All BTB valid = 0.
  - GHR = 0.
- Index and tag:
  - bht_idx = pc[BHT_IDX_BITS+1:2]
  - btb_idx = pc[BTB_IDX_BITS+1:2]
  - tag = pc[31:BTB_IDX_BITS+2]
- Prediction (combinational from if_pc, zero latency):
  - hit = valid & tag match.
  - pred_taken = hit & (is_jump | cnt[bht_idx][1]).
  - pred_target = pred_taken ? entry.target : if_pc + 4.
  - While rst=1: pred_taken = 0 and pred_target = if_pc + 4.
- Resolution (combinational, EX):
  - actual = op_jal | op_jalr | (op_br & ex_br_en).
  - prediction_failed = ex_valid & ~rst & ((actual != ex_pred_taken) | (actual & ex_pred_target != ex_target)).
  - redirect_pc = actual ? ex_target : ex_pc + 4.
  - Non-control opcodes have actual = 0; a stale predicted-taken on such an instruction is flagged as failed.
- Update (at clk edge, only when upd = ex_valid & predict_en & ~rst and the opcode is op_br, op_jal or op_jalr):
  - op_br counter update:
    - Taken increments the counter, saturating at 11.
    - Not-taken decrements it, saturating at 00.
  - BTB write if actual: valid = 1, tag, target = ex_target, is_jump = (opcode != op_br). Any existing entry is overwritten.
  - op_br not taken: BTB left unchanged.
- Stall handling:
  - predict_en = 0 suppresses all writes, so an EX instruction held over N stall cycles updates exactly once, on the cycle predict_en = 1.
- Same-cycle read/write to the same index:
  - The prediction uses the pre-update value (no bypass).
- Aliasing:
  - Counter table is untagged, so aliasing is accepted.
  - BTB tag mismatch counts as a miss.

Optional Feature:
- BP_GSHARE_EN defined:
  - bht_idx = pc[BHT_IDX_BITS+1:2] XOR zero-extended GHR (same for IF read and EX update).
  - The IF read uses the current GHR. The EX update uses the GHR value carried from IF via an extra input `ex_ghr[GHR_BITS-1:0]` and output `pred_ghr[GHR_BITS-1:0]` (both present only with the macro).
  - GHR shifts in `actual` on each op_br update (non-speculative).
- BP_GSHARE_EN undefined:
  - No GHR and no extra ports; pure bimodal indexing.

Decomposition:
- Package bp_types:
  - enum bp_cnt_t {STRONG_NT = 2'b00, WEAK_NT, WEAK_T, STRONG_T}
  - struct btb_entry_t
  - function sat_update(bp_cnt_t, logic taken)
  - localparam BP_CNT_RESET = WEAK_NT
- Sub-module: `btb` (tag/target array with read and write ports); the counter table stays in the top.

Test Plan:
- Reset, then if_pc = 0x60 → pred_taken = 0, pred_target = 0x64; prediction_failed = 0 even with ex_valid = 1 while rst = 1.
- op_br at ex_pc 0x80, ex_target 0x40, br_en = 1, ex_pred_taken = 0 → prediction_failed = 1, redirect_pc = 0x40 the same cycle. Next cycle, if_pc = 0x80 → pred_taken = 1 (counter 10), pred_target = 0x40.
- Four taken updates at 0x80 drive the counter to 11. Then one not-taken with ex_pred_taken = 1 → failed = 1, redirect_pc = 0x84, counter = 10, and the next fetch still predicts taken.
- predict_en = 0 for 3 cycles while EX holds a taken op_br at 0x80 (counter 01), then 1 → counter = 10, not 11.
- BTB holds 0x80; if_pc = 0x80 + 4·32 = 0x100 → BTB miss, pred_taken = 0.
- op_jalr at 0x200 with ex_pred_taken = 1, ex_pred_target = 0x300, ex_target = 0x310 → failed = 1, redirect_pc = 0x310, BTB target updated to 0x310 with is_jump = 1.
